seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 60 ++++++
 tb/tb_seq_detector_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parameterized serial pattern detector with a registered match flag and a saturating
// match counter. It supports overlapped and non-overlapped detection.
module seq_detector_param #(
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               DATA_in,
  input  logic               data_valid,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap_en,
  input  logic               clear,
  output logic               DATA_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int             FW       = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist, hist_n;
  logic [FW-1:0]      fill, fill_n;
  logic               match;

  // Next-state history and fill are computed for every cycle.
  // They are committed only in valid cycles that are not cleared.
  always_comb begin
    hist_n = {hist[PAT_LEN-2:0], DATA_in};
    fill_n = (fill == FILL_MAX) ? fill : fill + FW'(1);
    match  = data_valid && !clear && (fill_n == FILL_MAX) && (hist_n == pattern);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hist        <= '0;
      fill        <= '0;
      DATA_out    <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      hist        <= '0;
      fill        <= '0;
      DATA_out    <= 1'b0;
      match_count <= '0;
    end else if (data_valid) begin
      hist     <= hist_n;
      // In non-overlapped mode a match consumes the window, so a fresh window is needed next.
      fill     <= (match && !overlap_en) ? '0 : fill_n;
      DATA_out <= match;
      if (match && (match_count != CNT_MAX))
        match_count <= match_count + CNT_W'(1);
    end else begin
      DATA_out <= 1'b0;
    end
  end

  assign count_sat = (match_count == CNT_MAX);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: it drives two configurations, (5,8) and (2,2),
// with shared stimulus and checks them against a window-based model and literal expectations.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       din = 1'b0, dv = 1'b0, ov = 1'b1, clr = 1'b0;
  logic [4:0] pat1 = 5'b10111;
  logic [1:0] pat2 = 2'b11;

  logic       out1, sat1, out2, sat2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(5), .CNT_W(8)) dut1 (
    .clk(clk), .res_n(res_n), .DATA_in(din), .data_valid(dv), .pattern(pat1),
    .overlap_en(ov), .clear(clr), .DATA_out(out1), .match_count(cnt1), .count_sat(sat1)
  );

  seq_detector_param #(.PAT_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .res_n(res_n), .DATA_in(din), .data_valid(dv), .pattern(pat2),
    .overlap_en(ov), .clear(clr), .DATA_out(out2), .match_count(cnt2), .count_sat(sat2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: every accepted bit is kept with its index since reset or clear.
  // A match needs the last PAT_LEN bits to equal the pattern.
  // Those bits must also lie at or after the start of the current window.
  int  mplen [2] = '{5, 2};
  int  mcmax [2] = '{255, 3};
  bit  mbits [2][64];
  int  mn    [2] = '{0, 0};
  int  mstart[2] = '{0, 0};
  int  mcnt  [2] = '{0, 0};
  bit  mout  [2] = '{0, 0};

  always @(posedge clk or negedge res_n) begin
    for (int d = 0; d < 2; d++) begin
      logic [31:0] pv;
      bit          hit;
      pv = (d == 0) ? 32'(pat1) : 32'(pat2);
      if (!res_n || clr) begin
        mn[d] = 0; mstart[d] = 0; mcnt[d] = 0; mout[d] = 0;
      end else if (dv) begin
        mbits[d][mn[d] % 64] = din;
        mn[d]++;
        hit = (mn[d] - mstart[d]) >= mplen[d];
        for (int k = 0; k < mplen[d]; k++)
          if (hit && mbits[d][(mn[d] - mplen[d] + k) % 64] != pv[mplen[d] - 1 - k]) hit = 0;
        if (hit && !ov) mstart[d] = mn[d];
        if (hit && mcnt[d] < mcmax[d]) mcnt[d]++;
        mout[d] = hit;
      end else begin
        mout[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_out1", int'(out1), int'(mout[0]));
    chk("model_cnt1", int'(cnt1), mcnt[0]);
    chk("model_sat1", int'(sat1), int'(mcnt[0] == mcmax[0]));
    chk("model_out2", int'(out2), int'(mout[1]));
    chk("model_cnt2", int'(cnt2), mcnt[1]);
    chk("model_sat2", int'(sat2), int'(mcnt[1] == mcmax[1]));
  end

  task automatic send(input logic b, input logic e1);
    din = b; dv = 1'b1;
    @(negedge clk);
    chk("lit_out1", int'(out1), int'(e1));
  endtask

  task automatic idle();
    dv = 1'b0;
    @(negedge clk);
    chk("lit_gap_out1", int'(out1), 0);
  endtask

  task automatic do_clear();
    clr = 1'b1; dv = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("lit_clr_cnt1", int'(cnt1), 0);
    chk("lit_clr_out1", int'(out1), 0);
    chk("lit_clr_sat2", int'(sat2), 0);
  endtask

  initial begin
    int e_cnt[6] = '{0, 1, 2, 3, 3, 3};
    int e_sat[6] = '{0, 0, 0, 1, 1, 1};
    int e_out[6] = '{0, 1, 1, 1, 1, 1};

    repeat (2) @(negedge clk);
    chk("rst_out1", int'(out1), 0);
    chk("rst_cnt1", int'(cnt1), 0);
    chk("rst_sat1", int'(sat1), 0);
    chk("rst_cnt2", int'(cnt2), 0);
    res_n = 1'b1;

    // Overlapped stream 1,0,1,1,1,0,1,1,1 gives pulses after bits 5 and 9.
    ov = 1'b1;
    send(1,0); send(0,0); send(1,0); send(1,0); send(1,1);
    send(0,0); send(1,0); send(1,0); send(1,1);
    idle();
    chk("ovl_cnt1", int'(cnt1), 2);

    // With non-overlapped detection the same stream gives only the first pulse.
    do_clear();
    ov = 1'b0;
    send(1,0); send(0,0); send(1,0); send(1,0); send(1,1);
    send(0,0); send(1,0); send(1,0); send(1,0);
    idle();
    chk("novl_cnt1", int'(cnt1), 1);

    // A gap of three invalid cycles between bits 2 and 3 leaves the bit positions unchanged.
    do_clear();
    ov = 1'b1;
    send(1,0); send(0,0);
    idle(); idle(); idle();
    send(1,0); send(1,0); send(1,1);
    idle();
    send(0,0); send(1,0); send(1,0); send(1,1);
    idle();
    chk("gap_cnt1", int'(cnt1), 2);

    // Send a partial 1,0,1,1, then pulse reset in mid-cycle.
    // The history from before the pulse must not complete a match.
    send(1,0); send(0,0); send(1,0); send(1,0);
    dv = 1'b0;
    chk("pre_rst_cnt1", int'(cnt1), 2);
    #3 res_n = 1'b0;
    #1;
    chk("async_out1", int'(out1), 0);
    chk("async_cnt1", int'(cnt1), 0);
    chk("async_sat2", int'(sat2), 0);
    chk("async_cnt2", int'(cnt2), 0);
    res_n = 1'b1;
    @(negedge clk);
    send(1,0);
    send(0,0); send(1,0); send(1,0); send(1,1);
    chk("post_rst_cnt1", int'(cnt1), 1);

    // The counter saturates at 3 for the two-bit pattern 11 driven with six 1s.
    do_clear();
    ov = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 1'b1; dv = 1'b1;
      @(negedge clk);
      chk("sat_out2", int'(out2), e_out[i]);
      chk("sat_cnt2", int'(cnt2), e_cnt[i]);
      chk("sat_flag2", int'(sat2), e_sat[i]);
    end
    idle();
    chk("sat_hold_cnt2", int'(cnt2), 3);

    // A clear in the same cycle as a valid bit discards that bit.
    do_clear();
    send(1,0); send(0,0); send(1,0); send(1,0);
    din = 1'b1; dv = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrv_out1", int'(out1), 0);
    chk("clrv_cnt1", int'(cnt1), 0);
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,0); send(1,1);
    chk("clrv_fresh_cnt1", int'(cnt1), 1);

    // For the all-zero pattern no match occurs before five bits have arrived.
    // The overlap mode is switched while the stream is running.
    do_clear();
    pat1 = 5'b00000;
    send(0,0); send(0,0); send(0,0); send(0,0); send(0,1); send(0,1);
    ov = 1'b0;
    send(0,1); send(0,0); send(0,0);
    idle();
    chk("zero_cnt1", int'(cnt1), 3);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
